// File: rtl/lsu_arbiter_pkg.sv
// Shared types and constants for the two-port LSU arbiter.
package lsu_arbiter_pkg;

   localparam int LSU_AW = 12;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   typedef struct packed {
      logic              we;
      logic [LSU_AW-1:0] addr;
      logic [31:0]       wdata;
      logic [3:0]        mask;
      logic              unsign;
   } lsu_req_t;

   // True when the mask is not a legal size or the address is misaligned for it.
   function automatic logic align_err(input logic [3:0] mask, input logic [1:0] addr_lo);
      if (mask == MASK_B)      return 1'b0;
      else if (mask == MASK_H) return addr_lo[0];
      else if (mask == MASK_W) return (addr_lo != 2'b00);
      else                     return 1'b1;
   endfunction

endpackage

// File: rtl/lsu_arbiter_rr_arb2.sv
// Stateless two-input round-robin grant; the caller keeps last_grant.
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   input  logic       i_accept,
   output logic [1:0] o_gnt
);

   assign o_gnt[0] = i_accept & i_req[0] & (~i_req[1] | i_last_grant);
   assign o_gnt[1] = i_accept & i_req[1] & (~i_req[0] | ~i_last_grant);

endmodule

// File: rtl/lsu_arbiter.sv
// Two-port sequencer sharing one LSU path, one transaction in flight.
// Optional request alignment checking: define LSU_ARBITER_ALIGN_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for a request; grant and capture on handshake
// ACCESS | one-cycle LSU access (only cycle st_en may be high)
// WAIT   | counting out the load latency
// RESP   | one-cycle response pulse to the owning port
module lsu_arbiter
   import lsu_arbiter_pkg::*;
#(
   parameter int LD_LATENCY = 1,
   parameter int AW         = LSU_AW
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req0_valid_i,
   output logic          req0_ready_o,
   input  logic          req0_we_i,
   input  logic [AW-1:0] req0_addr_i,
   input  logic [31:0]   req0_wdata_i,
   input  logic [3:0]    req0_mask_i,
   input  logic          req0_unsign_i,
   output logic          rsp0_valid_o,
   output logic [31:0]   rsp0_rdata_o,
   output logic          rsp0_err_o,
   input  logic          req1_valid_i,
   output logic          req1_ready_o,
   input  logic          req1_we_i,
   input  logic [AW-1:0] req1_addr_i,
   input  logic [31:0]   req1_wdata_i,
   input  logic [3:0]    req1_mask_i,
   input  logic          req1_unsign_i,
   output logic          rsp1_valid_o,
   output logic [31:0]   rsp1_rdata_o,
   output logic          rsp1_err_o,
   output logic          lsu_st_en_o,
   output logic [AW-1:0] lsu_addr_o,
   output logic [31:0]   lsu_st_data_o,
   output logic [3:0]    lsu_mask_o,
   output logic          lsu_unsign_o,
   input  logic [31:0]   lsu_ld_data_i
);

   localparam logic [1:0] CNT_INIT = (LD_LATENCY > 0) ? 2'(LD_LATENCY - 1) : 2'd0;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_last;
   logic       r_port;
   lsu_req_t   r_req;
   logic [31:0] r_rdata;
   logic [1:0] r_cnt;

   logic [1:0] w_gnt;
   logic       w_hs;
   logic       w_err;
   lsu_req_t   w_sel;
   logic       w_rsp0;
   logic       w_rsp1;

   rr_arb2 u_arb (
      .i_req        ({req1_valid_i, req0_valid_i}),
      .i_last_grant (r_last),
      .i_accept     (r_state == IDLE),
      .o_gnt        (w_gnt)
   );

   assign w_hs = |w_gnt;
   assign req0_ready_o = w_gnt[0];
   assign req1_ready_o = w_gnt[1];

   assign w_sel = w_gnt[1]
      ? '{we: req1_we_i, addr: req1_addr_i, wdata: req1_wdata_i, mask: req1_mask_i, unsign: req1_unsign_i}
      : '{we: req0_we_i, addr: req0_addr_i, wdata: req0_wdata_i, mask: req0_mask_i, unsign: req0_unsign_i};

`ifdef LSU_ARBITER_ALIGN_CHECK_EN
   logic r_err;

   assign w_err = w_hs & align_err(w_sel.mask, w_sel.addr[1:0]);

   always_ff @(posedge clk_i) begin
      if (rst_i)     r_err <= 1'b0;
      else if (w_hs) r_err <= w_err;
   end

   assign rsp0_err_o = w_rsp0 & r_err;
   assign rsp1_err_o = w_rsp1 & r_err;
`else
   assign w_err      = 1'b0;
   assign rsp0_err_o = 1'b0;
   assign rsp1_err_o = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_hs) w_state_nxt = w_err ? RESP : ACCESS;
         ACCESS:  w_state_nxt = (r_req.we || LD_LATENCY == 0) ? RESP : WAIT;
         WAIT:    if (r_cnt == 2'd0) w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_port  <= 1'b0;
         r_req   <= '0;
         r_rdata <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_hs) begin
            r_last  <= w_gnt[1];
            r_port  <= w_gnt[1];
            r_rdata <= '0;
            // Rejected requests leave the LSU-facing registers untouched.
            if (!w_err) r_req <= w_sel;
         end
         if (r_state == ACCESS) begin
            r_cnt <= CNT_INIT;
            if (r_req.we)              r_rdata <= '0;
            else if (LD_LATENCY == 0)  r_rdata <= lsu_ld_data_i;
         end
         if (r_state == WAIT) begin
            r_cnt <= r_cnt - 2'd1;
            if (r_cnt == 2'd0) r_rdata <= lsu_ld_data_i;
         end
      end
   end

   assign lsu_st_en_o   = (r_state == ACCESS) & r_req.we;
   assign lsu_addr_o    = r_req.addr;
   assign lsu_st_data_o = r_req.wdata;
   assign lsu_mask_o    = r_req.mask;
   assign lsu_unsign_o  = r_req.unsign;

   assign w_rsp0 = (r_state == RESP) & ~r_port;
   assign w_rsp1 = (r_state == RESP) &  r_port;

   assign rsp0_valid_o = w_rsp0;
   assign rsp1_valid_o = w_rsp1;
   assign rsp0_rdata_o = w_rsp0 ? r_rdata : 32'd0;
   assign rsp1_rdata_o = w_rsp1 ? r_rdata : 32'd0;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: LSU memory model plus response scoreboard.
module tb_lsu_arbiter;

   localparam int LAT = 1;
   localparam int AW  = 12;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          req0_valid_i, req0_ready_o, req0_we_i, req0_unsign_i;
   logic [AW-1:0] req0_addr_i;
   logic [31:0]   req0_wdata_i;
   logic [3:0]    req0_mask_i;
   logic          rsp0_valid_o, rsp0_err_o;
   logic [31:0]   rsp0_rdata_o;
   logic          req1_valid_i, req1_ready_o, req1_we_i, req1_unsign_i;
   logic [AW-1:0] req1_addr_i;
   logic [31:0]   req1_wdata_i;
   logic [3:0]    req1_mask_i;
   logic          rsp1_valid_o, rsp1_err_o;
   logic [31:0]   rsp1_rdata_o;
   logic          lsu_st_en_o, lsu_unsign_o;
   logic [AW-1:0] lsu_addr_o;
   logic [31:0]   lsu_st_data_o;
   logic [3:0]    lsu_mask_o;
   logic [31:0]   lsu_ld_data_i;

   typedef struct {
      int          port;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          grant_log[$];
   int          n_asrt = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          data_cyc = -1;
   int          st_cnt = 0;
   int          st_last = -1;
   logic        ovr_en = 1'b0;
   logic [31:0] ovr_val = '0;
   logic [31:0] mem [1024];

   lsu_arbiter #(.LD_LATENCY(LAT), .AW(AW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
      .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i), .req0_mask_i(req0_mask_i),
      .req0_unsign_i(req0_unsign_i), .rsp0_valid_o(rsp0_valid_o), .rsp0_rdata_o(rsp0_rdata_o),
      .rsp0_err_o(rsp0_err_o),
      .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
      .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i), .req1_mask_i(req1_mask_i),
      .req1_unsign_i(req1_unsign_i), .rsp1_valid_o(rsp1_valid_o), .rsp1_rdata_o(rsp1_rdata_o),
      .rsp1_err_o(rsp1_err_o),
      .lsu_st_en_o(lsu_st_en_o), .lsu_addr_o(lsu_addr_o), .lsu_st_data_o(lsu_st_data_o),
      .lsu_mask_o(lsu_mask_o), .lsu_unsign_o(lsu_unsign_o), .lsu_ld_data_i(lsu_ld_data_i)
   );

   initial forever #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // LSU model: load data is only valid in the cycle the latency says it should be.
   assign lsu_ld_data_i = (cyc == data_cyc) ? (ovr_en ? ovr_val : mem[lsu_addr_o[11:2]])
                                            : 32'hBAD0_BAD0;

   always @(posedge clk_i)
      if (lsu_st_en_o)
         for (int b = 0; b < 4; b++)
            if (lsu_mask_o[b]) mem[lsu_addr_o[11:2]][8*b +: 8] <= lsu_st_data_o[8*b +: 8];

   always @(negedge clk_i)
      if (lsu_st_en_o) begin
         st_cnt  = st_cnt + 1;
         st_last = cyc;
      end

   function automatic logic [31:0] init_word(input logic [11:0] a);
      return 32'hA500_0000 | {22'd0, a[11:2]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk_i) begin
      exp_t e;
      if (rsp0_valid_o || rsp1_valid_o) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", {62'd0, rsp1_valid_o, rsp0_valid_o}, 64'd0);
         end else begin
            e = sb.pop_front();
            check("rsp_owner", {62'd0, rsp1_valid_o, rsp0_valid_o}, (e.port == 1) ? 64'd2 : 64'd1);
            check("rsp_rdata", (e.port == 1) ? rsp1_rdata_o : rsp0_rdata_o, e.rdata);
            check("rsp_err", (e.port == 1) ? rsp1_err_o : rsp0_err_o, e.err);
            check("rsp_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic drive(input int p, input logic v, input logic we, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] m, input logic u);
      if (p == 0) begin
         req0_valid_i = v; req0_we_i = we; req0_addr_i = a;
         req0_wdata_i = wd; req0_mask_i = m; req0_unsign_i = u;
      end else begin
         req1_valid_i = v; req1_we_i = we; req1_addr_i = a;
         req1_wdata_i = wd; req1_mask_i = m; req1_unsign_i = u;
      end
   endtask

   task automatic issue(input int p, input logic we, input logic [11:0] a, input logic [31:0] wd,
                        input logic [3:0] m, input logic u, input logic [31:0] exp_rd,
                        input logic exp_err, output int t_hs);
      exp_t e;
      bit   got = 0;
      t_hs = -1;
      @(negedge clk_i);
      drive(p, 1'b1, we, a, wd, m, u);
      for (int k = 0; k < 60 && !got; k++) begin
         #1;
         if ((p == 0) ? req0_ready_o : req1_ready_o) got = 1;
         else @(negedge clk_i);
      end
      check("handshake", {63'd0, got}, 64'd1);
      if (got) begin
         t_hs    = cyc;
         e.port  = p;
         e.rdata = exp_rd;
         e.err   = exp_err;
         e.cyc   = cyc + (exp_err ? 1 : (we ? 2 : 2 + LAT));
         sb.push_back(e);
         grant_log.push_back(p);
         if (!we) data_cyc = cyc + 1 + LAT;
      end
      @(posedge clk_i); #1;
      drive(p, 1'b0, 1'b1, 12'hFFC, 32'h0BAD_F00D, 4'h5, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = init_word(12'(i * 4));
   end

   initial begin
      int t, st_before;
      rst_i = 1'b1;
      drive(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      drive(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      do_reset();

      // reset state
      @(negedge clk_i);
      check("reset_ctrl", {40'd0, req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp0_err_o,
            rsp1_err_o, lsu_st_en_o, lsu_unsign_o, lsu_mask_o, lsu_addr_o}, 64'd0);
      check("reset_data", {lsu_st_data_o, rsp0_rdata_o | rsp1_rdata_o}, 64'd0);

      // round-robin with both ports continuously requesting loads
      fork
         begin
            int ta;
            for (int k = 0; k < 3; k++)
               issue(0, 1'b0, 12'(12'h100 + k * 8), '0, 4'hF, 1'b0, init_word(12'(12'h100 + k * 8)), 1'b0, ta);
         end
         begin
            int tb;
            for (int k = 0; k < 3; k++)
               issue(1, 1'b0, 12'(12'h104 + k * 8), '0, 4'hF, 1'b0, init_word(12'(12'h104 + k * 8)), 1'b0, tb);
         end
      join
      check("rr_count", grant_log.size(), 6);
      for (int i = 0; i < grant_log.size(); i++) check("rr_order", grant_log[i], i % 2);
      repeat (4) @(negedge clk_i);

      // word store then load-back
      st_before = st_cnt;
      issue(0, 1'b1, 12'h010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'd0, 1'b0, t);
      check("st_access", {lsu_st_en_o, lsu_addr_o, lsu_mask_o, lsu_st_data_o}, {1'b1, 12'h010, 4'hF, 32'hDEAD_BEEF});
      @(posedge clk_i); #1;
      check("st_en_resp", lsu_st_en_o, 1'b0);
      issue(0, 1'b0, 12'h010, '0, 4'hF, 1'b1, 32'hDEAD_BEEF, 1'b0, t);
      repeat (4) @(negedge clk_i);
      check("st_en_pulses", st_cnt - st_before, 1);
      check("st_en_cycle", st_last, t - 2);

      // signed byte load; mask/unsign must stay put through WAIT and RESP
      ovr_en = 1'b1; ovr_val = 32'hFFFF_FF80;
      issue(0, 1'b0, 12'h013, '0, 4'h1, 1'b0, 32'hFFFF_FF80, 1'b0, t);
      for (int k = 0; k < 3; k++) begin
         check("byte_hold", {lsu_addr_o, lsu_mask_o, lsu_unsign_o}, {12'h013, 4'h1, 1'b0});
         @(posedge clk_i); #1;
      end
      ovr_en = 1'b0;
      repeat (2) @(negedge clk_i);

      // port 1 waits while port 0 is busy; only handshake-cycle fields count
      issue(0, 1'b0, 12'h020, '0, 4'hF, 1'b0, init_word(12'h020), 1'b0, t);
      drive(1, 1'b1, 1'b1, 12'hFFC, 32'h0BAD_F00D, 4'hF, 1'b1);
      for (int k = 0; k < 3; k++) begin
         check("p1_blocked", req1_ready_o, 1'b0);
         @(posedge clk_i); #1;
      end
      drive(1, 1'b1, 1'b0, 12'h024, '0, 4'hF, 1'b0);
      #1;
      check("p1_granted", {req1_ready_o, req0_ready_o}, 2'b10);
      begin
         exp_t e;
         e.port = 1; e.rdata = init_word(12'h024); e.err = 1'b0; e.cyc = cyc + 2 + LAT;
         sb.push_back(e);
         data_cyc = cyc + 1 + LAT;
      end
      @(posedge clk_i); #1;
      drive(1, 1'b0, 1'b1, 12'hFFC, 32'h0BAD_F00D, 4'h5, 1'b1);
      repeat (4) @(negedge clk_i);

      // reset during WAIT aborts with no response
      issue(0, 1'b0, 12'h030, '0, 4'hF, 1'b1, init_word(12'h030), 1'b0, t);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      void'(sb.pop_back());
      check("abort_ctrl", {40'd0, req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp0_err_o,
            rsp1_err_o, lsu_st_en_o, lsu_unsign_o, lsu_mask_o, lsu_addr_o}, 64'd0);
      check("abort_data", {lsu_st_data_o, rsp0_rdata_o | rsp1_rdata_o}, 64'd0);
      repeat (4) @(negedge clk_i);
      issue(1, 1'b1, 12'h040, 32'h1234_5678, 4'hF, 1'b0, 32'd0, 1'b0, t);
      issue(1, 1'b0, 12'h040, '0, 4'hF, 1'b0, 32'h1234_5678, 1'b0, t);
      repeat (4) @(negedge clk_i);

      // misaligned word load
      st_before = st_cnt;
`ifdef LSU_ARBITER_ALIGN_CHECK_EN
      issue(0, 1'b0, 12'h002, '0, 4'hF, 1'b0, 32'd0, 1'b1, t);
      repeat (4) @(negedge clk_i);
      check("align_addr", lsu_addr_o, 12'h040);
`else
      issue(0, 1'b0, 12'h002, '0, 4'hF, 1'b0, init_word(12'h002), 1'b0, t);
      repeat (4) @(negedge clk_i);
      check("align_addr", lsu_addr_o, 12'h002);
`endif
      check("align_st_en", st_cnt - st_before, 0);

      repeat (6) @(negedge clk_i);
      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
- Two-port arbiter/sequencer in front of the load-store unit (LSU). Shares the single LSU access path between requester 0 (core MEM stage) and requester 1 (debug/DMA loader).
- Registers each accepted request, drives the LSU for exactly one access, waits out the load latency, then returns a single-cycle response to the owning requester.
- One transaction is in flight at a time; arbitration is round-robin.

Parameters:
- LD_LATENCY, 1: cycles from the LSU access cycle until lsu_ld_data_i is valid (0..3).
- AW, 12: LSU byte-address width.

Ports:
- clk_i in 1: clock.
- rst_i in 1: synchronous active-high reset.
- reqN_valid_i in 1 (N=0,1): request valid.
- reqN_ready_o out 1: request accepted this cycle.
- reqN_we_i in 1: 1 = store, 0 = load.
- reqN_addr_i in AW: byte address.
- reqN_wdata_i in 32: store data.
- reqN_mask_i in 4: byte mask; legal values 0001 (byte), 0011 (half), 1111 (word).
- reqN_unsign_i in 1: zero-extend the load.
- rspN_valid_o out 1: one-cycle response pulse.
- rspN_rdata_o out 32: load data (0 for stores).
- rspN_err_o out 1: access rejected; see Optional Feature.
- lsu_st_en_o out 1: LSU store enable.
- lsu_addr_o out AW: LSU address.
- lsu_st_data_o out 32: LSU store data.
- lsu_mask_o out 4: LSU mask.
- lsu_unsign_o out 1: LSU unsigned-load select.
- lsu_ld_data_i in 32: LSU load data.

Behaviour:
- Clock is clk_i. Reset is rst_i: synchronous, active-high.
- Reset state:
  - FSM = IDLE, last_grant = 1 (so port 0 wins the first tie).
  - All outputs 0, including the lsu_* registers and rspN_*.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If any reqN_valid_i is high, grant one port. Only that port's reqN_ready_o = 1, combinationally in the same cycle.
  - On handshake, capture we/addr/wdata/mask/unsign/port into registers and go to ACCESS.
  - In IDLE, reqN_ready_o = 0 when reqN_valid_i = 0.
- Arbitration:
  - Exactly one valid: that port wins.
  - Both valid: the port not equal to last_grant wins.
  - last_grant updates only on a handshake.
- ACCESS (exactly 1 cycle):
  - lsu_addr_o/mask/unsign/st_data are driven from the captured registers.
  - lsu_st_en_o = captured we. This is the only cycle st_en can be 1.
  - Store, or LD_LATENCY = 0: sample lsu_ld_data_i (loads only; stores return 0) into the rdata register, then go to RESP.
  - Otherwise: load the wait counter with LD_LATENCY-1 and go to WAIT.
- WAIT:
  - Count down. At count 0, sample lsu_ld_data_i and go to RESP.
  - lsu_addr/mask/unsign are held stable throughout WAIT and RESP, because LSU load formatting depends on mask/unsign.
- RESP:
  - rspP_valid_o = 1 for the owning port P, for one cycle. rdata/err are valid in the same cycle.
  - Return to IDLE. No new grant is issued in RESP.
- Latency: handshake cycle T gives response in cycle T+2 (store) or T+2+LD_LATENCY (load).
  - Minimum issue interval: 3 cycles for stores, 3+LD_LATENCY cycles for loads.
- Outputs outside ACCESS/WAIT/RESP:
  - lsu_* data/addr registers hold their last value.
  - lsu_st_en_o = 0.
- A requester dropping valid after its handshake has no effect; the transaction completes.
- Reset mid-transaction: abort. A store asserted in ACCESS in the reset cycle is still presented, but st_en is forced 0 from the next cycle. No response is issued.
- Illegal mask without the feature: passed through to the LSU unchanged. The LSU returns 0 for such loads.

Optional Feature:
- Macro: LSU_ARBITER_ALIGN_CHECK_EN.
- When defined, a request is flagged as an error in IDLE on handshake if:
  - the mask is illegal, or
  - half access with addr[0] = 1, or
  - word access with addr[1:0] != 0.
- A flagged request skips ACCESS/WAIT:
  - lsu_st_en_o stays 0 and the lsu_* registers are not updated.
  - FSM goes directly to RESP with rspP_err_o = 1 and rdata = 0.
- When undefined: rspN_err_o is tied 0 and no checking logic is built.

Decomposition:
- Package lsu_arbiter_pkg contains:
  - state enum: IDLE, ACCESS, WAIT, RESP;
  - mask localparams: MASK_B = 4'b0001, MASK_H = 4'b0011, MASK_W = 4'b1111;
  - packed struct lsu_req_t {we, addr, wdata, mask, unsign}.
- One sub-module, rr_arb2:
  - 2-input round-robin grant: inputs req[1:0], last_grant, accept; outputs gnt[1:0].
  - Holds no state of its own; last_grant stays in the parent.

Test Plan:
- Port 0 store addr 0x010, data 0xDEADBEEF, mask 1111; then load 0x010, mask 1111, LD_LATENCY = 1 -> st_en is high exactly 1 cycle; rsp0 store at T+2; rsp0 load rdata = 0xDEADBEEF at T+3.
- Both ports valid continuously with loads -> grants alternate 0,1,0,1 starting with port 0; each rsp goes only to its owner; no responses are lost.
- Load byte at 0x013, mask 0001, unsign = 0, with LSU returning 0xFFFFFF80 -> rsp rdata = 0xFFFFFF80; lsu_mask_o/unsign are held through WAIT.
- Port 1 valid while a port 0 transaction is in WAIT -> req1_ready_o = 0 until IDLE; then granted; port 1 request fields are sampled at handshake only.
- rst_i asserted during WAIT -> next cycle: all outputs 0, FSM IDLE, no rsp pulse; a new request after reset completes normally.
- With LSU_ARBITER_ALIGN_CHECK_EN: word load at 0x002 -> lsu_st_en_o never rises, lsu_addr_o unchanged; rsp err = 1, rdata = 0 at T+1. Without the macro -> normal access, err = 0.
